// File: rtl/tri_bbox_rasteriser_if.sv
// Triangle-in / pixel-out handshake bundle for tri_bbox_rasteriser.
// slave is the rasteriser side; master is the fetch/consumer side.
interface tri_bbox_rasteriser_if #(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 19
);
    logic               tri_valid;
    logic               tri_ready;
    logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3;
    logic               pix_valid;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [ADDR_W-1:0]  pixel_number;
    logic               tri_done;
    logic               frame_req;
    logic               frame_done;

    modport master (
        output tri_valid, x1, y1, x2, y2, x3, y3, pix_ready, frame_req,
        input  tri_ready, pix_valid, pix_x, pix_y, pixel_number, tri_done, frame_done
    );

    modport slave (
        input  tri_valid, x1, y1, x2, y2, x3, y3, pix_ready, frame_req,
        output tri_ready, pix_valid, pix_x, pix_y, pixel_number, tri_done, frame_done
    );
endinterface

// File: rtl/tri_bbox_rasteriser.sv
// Bounding-box triangle rasteriser with incremental edge functions, one pixel per cycle.
// Define RAST_CULL_EN to cull negative-area (clockwise) triangles instead of rasterising them.
//
// state   | meaning
// IDLE    | tri_ready high; waits for a triangle or a frame request
// SETUP   | bounding box, clipping and area sign; rejects empty/degenerate/culled
// INIT    | edge values at the min corner, winding normalisation
// SCAN    | row-major walk of the clipped box, emits covered pixels
// FRAME   | frame_done held until frame_req drops
module tri_bbox_rasteriser #(
    parameter int COORD_W = 16,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int ADDR_W  = 19
) (
    input logic                  clk,
    input logic                  reset,
    tri_bbox_rasteriser_if.slave bus
);

    localparam int EW = 2 * COORD_W + 3;
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(FRAME_H - 1);

    typedef logic signed [EW-1:0] edge_t;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INIT, S_SCAN, S_FRAME} state_t;

    function automatic edge_t sx(input logic [COORD_W-1:0] c);
        return edge_t'({{(EW - COORD_W){1'b0}}, c});
    endfunction

    function automatic edge_t edge_fn(input edge_t px, input edge_t py, input edge_t xa,
                                      input edge_t ya, input edge_t xb, input edge_t yb);
        return (px - xa) * (yb - ya) - (py - ya) * (xb - xa);
    endfunction

    state_t             state_q, state_d;
    logic [COORD_W-1:0] vx_q [3], vx_d [3];
    logic [COORD_W-1:0] vy_q [3], vy_d [3];
    logic [COORD_W-1:0] min_x_q, min_x_d, min_y_q, min_y_d;
    logic [COORD_W-1:0] max_x_q, max_x_d, max_y_q, max_y_d;
    logic               area_neg_q, area_neg_d;
    edge_t              stx_q [3], stx_d [3];
    edge_t              sty_q [3], sty_d [3];
    edge_t              row_q [3], row_d [3];
    edge_t              cur_q [3], cur_d [3];
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [ADDR_W-1:0]  pnum_q, pnum_d;
    logic               pix_valid_q, pix_valid_d;
    logic               tri_ready_q, tri_ready_d;
    logic               tri_done_q, tri_done_d;
    logic               frame_done_q, frame_done_d;

    edge_t              area_c;
    edge_t              e_c [3];
    edge_t              stx_c [3];
    edge_t              sty_c [3];
    logic [COORD_W-1:0] bb_mnx, bb_mny, bb_mxx, bb_mxy;
    logic               empty_c, cull_c, covered_c;

    always_comb begin
        state_d    = state_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        min_x_d    = min_x_q;
        min_y_d    = min_y_q;
        max_x_d    = max_x_q;
        max_y_d    = max_y_q;
        area_neg_d = area_neg_q;
        stx_d      = stx_q;
        sty_d      = sty_q;
        row_d      = row_q;
        cur_d      = cur_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        tri_done_d = 1'b0;

        area_c = edge_fn(sx(vx_q[2]), sx(vy_q[2]), sx(vx_q[0]), sx(vy_q[0]),
                         sx(vx_q[1]), sx(vy_q[1]));
        bb_mnx = vx_q[0];
        bb_mxx = vx_q[0];
        bb_mny = vy_q[0];
        bb_mxy = vy_q[0];
        for (int i = 1; i < 3; i++) begin
            if (vx_q[i] < bb_mnx) bb_mnx = vx_q[i];
            if (vx_q[i] > bb_mxx) bb_mxx = vx_q[i];
            if (vy_q[i] < bb_mny) bb_mny = vy_q[i];
            if (vy_q[i] > bb_mxy) bb_mxy = vy_q[i];
        end
        if (bb_mxx > X_LIM) bb_mxx = X_LIM;
        if (bb_mxy > Y_LIM) bb_mxy = Y_LIM;
        empty_c = (bb_mnx > bb_mxx) || (bb_mny > bb_mxy);
`ifdef RAST_CULL_EN
        cull_c = area_c[EW-1];
`else
        cull_c = 1'b0;
`endif

        e_c[0] = edge_fn(sx(min_x_q), sx(min_y_q), sx(vx_q[0]), sx(vy_q[0]), sx(vx_q[1]), sx(vy_q[1]));
        e_c[1] = edge_fn(sx(min_x_q), sx(min_y_q), sx(vx_q[1]), sx(vy_q[1]), sx(vx_q[2]), sx(vy_q[2]));
        e_c[2] = edge_fn(sx(min_x_q), sx(min_y_q), sx(vx_q[2]), sx(vy_q[2]), sx(vx_q[0]), sx(vy_q[0]));
        stx_c[0] = sx(vy_q[1]) - sx(vy_q[0]);
        sty_c[0] = sx(vx_q[0]) - sx(vx_q[1]);
        stx_c[1] = sx(vy_q[2]) - sx(vy_q[1]);
        sty_c[1] = sx(vx_q[1]) - sx(vx_q[2]);
        stx_c[2] = sx(vy_q[0]) - sx(vy_q[2]);
        sty_c[2] = sx(vx_q[2]) - sx(vx_q[0]);
        // Clockwise winding: flip every edge so "inside" is always non-negative.
        if (area_neg_q) begin
            for (int i = 0; i < 3; i++) begin
                e_c[i]   = -e_c[i];
                stx_c[i] = -stx_c[i];
                sty_c[i] = -sty_c[i];
            end
        end
        covered_c = !cur_q[0][EW-1] && !cur_q[1][EW-1] && !cur_q[2][EW-1];

        case (state_q)
            S_IDLE: begin
                if (bus.tri_valid) begin
                    vx_d[0] = bus.x1;
                    vy_d[0] = bus.y1;
                    vx_d[1] = bus.x2;
                    vy_d[1] = bus.y2;
                    vx_d[2] = bus.x3;
                    vy_d[2] = bus.y3;
                    state_d = S_SETUP;
                end else if (bus.frame_req) begin
                    state_d = S_FRAME;
                end
            end
            S_SETUP: begin
                min_x_d    = bb_mnx;
                min_y_d    = bb_mny;
                max_x_d    = bb_mxx;
                max_y_d    = bb_mxy;
                area_neg_d = area_c[EW-1];
                if ((area_c == '0) || empty_c || cull_c) begin
                    state_d    = S_IDLE;
                    tri_done_d = 1'b1;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                row_d   = e_c;
                cur_d   = e_c;
                stx_d   = stx_c;
                sty_d   = sty_c;
                cur_x_d = min_x_q;
                cur_y_d = min_y_q;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (!covered_c || bus.pix_ready) begin
                    if (cur_x_q == max_x_q) begin
                        if (cur_y_q == max_y_q) begin
                            state_d    = S_IDLE;
                            tri_done_d = 1'b1;
                        end else begin
                            cur_x_d = min_x_q;
                            cur_y_d = cur_y_q + 1'b1;
                            for (int i = 0; i < 3; i++) begin
                                row_d[i] = row_q[i] + sty_q[i];
                                cur_d[i] = row_q[i] + sty_q[i];
                            end
                        end
                    end else begin
                        cur_x_d = cur_x_q + 1'b1;
                        for (int i = 0; i < 3; i++) cur_d[i] = cur_q[i] + stx_q[i];
                    end
                end
            end
            S_FRAME: begin
                if (!bus.frame_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pix_valid_d  = (state_d == S_SCAN) && !cur_d[0][EW-1] && !cur_d[1][EW-1] && !cur_d[2][EW-1];
        tri_ready_d  = (state_d == S_IDLE);
        frame_done_d = (state_d == S_FRAME);
        pnum_d       = ADDR_W'(cur_y_d) * ADDR_W'(FRAME_W) + ADDR_W'(cur_x_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            vx_q         <= '{default: '0};
            vy_q         <= '{default: '0};
            min_x_q      <= '0;
            min_y_q      <= '0;
            max_x_q      <= '0;
            max_y_q      <= '0;
            area_neg_q   <= 1'b0;
            stx_q        <= '{default: '0};
            sty_q        <= '{default: '0};
            row_q        <= '{default: '0};
            cur_q        <= '{default: '0};
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            pnum_q       <= '0;
            pix_valid_q  <= 1'b0;
            tri_ready_q  <= 1'b1;
            tri_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            min_x_q      <= min_x_d;
            min_y_q      <= min_y_d;
            max_x_q      <= max_x_d;
            max_y_q      <= max_y_d;
            area_neg_q   <= area_neg_d;
            stx_q        <= stx_d;
            sty_q        <= sty_d;
            row_q        <= row_d;
            cur_q        <= cur_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            pnum_q       <= pnum_d;
            pix_valid_q  <= pix_valid_d;
            tri_ready_q  <= tri_ready_d;
            tri_done_q   <= tri_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tri_ready    = tri_ready_q;
    assign bus.pix_valid    = pix_valid_q;
    assign bus.pix_x        = cur_x_q;
    assign bus.pix_y        = cur_y_q;
    assign bus.pixel_number = pnum_q;
    assign bus.tri_done     = tri_done_q;
    assign bus.frame_done   = frame_done_q;

endmodule
